// File: rtl/video_sig_gen.sv
// 720p raster timing: pixel/line counters, syncs, active-draw,
// new-frame strobe and frame counter, all registered.
module video_sig_gen #(
  parameter int ACTIVE_H = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int ACTIVE_V = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int FPS      = 60
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out
);

  localparam int TOTAL_H = ACTIVE_H + H_FP + H_SYNC + H_BP;
  localparam int TOTAL_V = ACTIVE_V + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(TOTAL_H - 1);
  localparam logic [10:0] H_ACT  = 11'(ACTIVE_H);
  localparam logic [10:0] HS_BEG = 11'(ACTIVE_H + H_FP);
  localparam logic [10:0] HS_END = 11'(ACTIVE_H + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(TOTAL_V - 1);
  localparam logic [9:0]  V_ACT  = 10'(ACTIVE_V);
  localparam logic [9:0]  VS_BEG = 10'(ACTIVE_V + V_FP);
  localparam logic [9:0]  VS_END = 10'(ACTIVE_V + V_FP + V_SYNC);
  localparam logic [5:0]  FC_LAST = 6'(FPS - 1);

  logic [10:0] h_nxt;
  logic [9:0]  v_nxt;
  logic        nf_nxt;

  // Decode uses next counts so outputs align with the counts they accompany
  always_comb begin
    h_nxt = hcount_out + 11'd1;
    v_nxt = vcount_out;
    if (hcount_out == H_LAST) begin
      h_nxt = '0;
      v_nxt = (vcount_out == V_LAST) ? '0 : vcount_out + 10'd1;
    end
    nf_nxt = (h_nxt == H_ACT) && (v_nxt == V_ACT);
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      hcount_out <= H_LAST;
      vcount_out <= V_LAST;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      ad_out     <= 1'b0;
      nf_out     <= 1'b0;
      fc_out     <= '0;
    end else begin
      hcount_out <= h_nxt;
      vcount_out <= v_nxt;
      hs_out     <= (h_nxt >= HS_BEG) && (h_nxt < HS_END);
      vs_out     <= (v_nxt >= VS_BEG) && (v_nxt < VS_END);
      ad_out     <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      nf_out     <= nf_nxt;
      if (nf_nxt)
        fc_out <= (fc_out == FC_LAST) ? '0 : fc_out + 6'd1;
    end
  end

endmodule

// File: tb/tb_video_sig_gen.sv
// Bench for video_sig_gen on a shrunken raster (25x13) so that
// multi-frame and frame-counter-wrap sequences stay short.
module tb_video_sig_gen;

  localparam int AH = 16, HFP = 2, HSW = 3, HBP = 4;
  localparam int AV = 8, VFP = 1, VSW = 2, VBP = 2;
  localparam int FPS = 60;
  localparam int TH = AH + HFP + HSW + HBP;
  localparam int TV = AV + VFP + VSW + VBP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        hs, vs, ad, nf;
  logic [5:0]  fc;

  video_sig_gen #(
    .ACTIVE_H(AH), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .ACTIVE_V(AV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .FPS(FPS)
  ) dut (
    .pixel_clk_in(clk),
    .rst_n_in(rst_n),
    .hcount_out(hc),
    .vcount_out(vc),
    .hs_out(hs),
    .vs_out(vs),
    .ad_out(ad),
    .nf_out(nf),
    .fc_out(fc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        ad;
    logic        nf;
    logic [5:0]  fc;
  } outs_t;

  typedef struct {
    logic  rst_n;
    int    cycles;
    outs_t exp;
  } vec_t;

  outs_t sb[$];
  int checks = 0;
  int errors = 0;

  int mh, mv, mfc;
  int cyc = 0;
  int hs_run = 0, vs_run = 0, ad_run = 0;
  int last_nf = -1;
  int nf_cnt = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic outs_t decode(input int h, input int v, input int f);
    outs_t o;
    o.h  = 11'(h);
    o.v  = 10'(v);
    o.ad = (h < AH) && (v < AV);
    o.hs = (h >= AH + HFP) && (h <= AH + HFP + HSW - 1);
    o.vs = (v >= AV + VFP) && (v <= AV + VFP + VSW - 1);
    o.nf = (h == AH) && (v == AV);
    o.fc = 6'(f);
    return o;
  endfunction

  task automatic step(input logic r);
    outs_t e, a, p;
    rst_n = r;
    if (!r) begin
      mh = TH - 1;
      mv = TV - 1;
      mfc = 0;
      e = '0;
      e.h = 11'(mh);
      e.v = 10'(mv);
    end else begin
      if (mh == TH - 1) begin
        mh = 0;
        mv = (mv == TV - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      if (mh == AH && mv == AV) mfc = (mfc + 1) % FPS;
      e = decode(mh, mv, mfc);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    a = {hc, vc, hs, vs, ad, nf, fc};
    e = sb.pop_front();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL scoreboard: got %h want %h (cycle %0d)", a, e, cyc);
    end
    // same-cycle consistency of flags with the presented counts
    p = decode(int'(hc), int'(vc), int'(fc));
    checks++;
    if (r && {hs, vs, ad, nf} !== {p.hs, p.vs, p.ad, p.nf}) begin
      errors++;
      $display("FAIL protocol: h=%0d v=%0d got %b want %b", hc, vc,
               {hs, vs, ad, nf}, {p.hs, p.vs, p.ad, p.nf});
    end
    if (!r) begin
      hs_run = 0;
      vs_run = 0;
      ad_run = 0;
      last_nf = -1;
      nf_cnt = 0;
    end else begin
      if (hs === 1'b1) hs_run++;
      else if (hs_run != 0) begin
        check("hs_width", hs_run, HSW);
        hs_run = 0;
      end
      if (vs === 1'b1) vs_run++;
      else if (vs_run != 0) begin
        check("vs_width", vs_run, VSW * TH);
        vs_run = 0;
      end
      if (ad === 1'b1) ad_run++;
      else if (ad_run != 0) begin
        check("ad_width", ad_run, AH);
        ad_run = 0;
      end
      if (nf === 1'b1) begin
        if (last_nf >= 0) check("nf_period", cyc - last_nf, TH * TV);
        last_nf = cyc;
        nf_cnt++;
        check("fc_on_nf", int'(fc), nf_cnt % FPS);
      end
    end
  endtask

  function automatic outs_t mk(input int h, input int v, input bit a,
                               input bit s, input bit vv, input bit n,
                               input int f);
    outs_t o;
    o.h = 11'(h);
    o.v = 10'(v);
    o.ad = a;
    o.hs = s;
    o.vs = vv;
    o.nf = n;
    o.fc = 6'(f);
    return o;
  endfunction

  vec_t vecs[13];

  initial begin
    outs_t a;
    //            rst  n     h   v  ad hs vs nf fc
    vecs[0]  = '{1'b0, 5,   mk(24, 12, 0, 0, 0, 0, 0)};
    vecs[1]  = '{1'b1, 1,   mk(0,  0,  1, 0, 0, 0, 0)};
    vecs[2]  = '{1'b1, 15,  mk(15, 0,  1, 0, 0, 0, 0)};
    vecs[3]  = '{1'b1, 1,   mk(16, 0,  0, 0, 0, 0, 0)};
    vecs[4]  = '{1'b1, 2,   mk(18, 0,  0, 1, 0, 0, 0)};
    vecs[5]  = '{1'b1, 2,   mk(20, 0,  0, 1, 0, 0, 0)};
    vecs[6]  = '{1'b1, 1,   mk(21, 0,  0, 0, 0, 0, 0)};
    vecs[7]  = '{1'b1, 4,   mk(0,  1,  1, 0, 0, 0, 0)};
    vecs[8]  = '{1'b1, 191, mk(16, 8,  0, 0, 0, 1, 1)};
    vecs[9]  = '{1'b1, 1,   mk(17, 8,  0, 0, 0, 0, 1)};
    vecs[10] = '{1'b1, 8,   mk(0,  9,  0, 0, 1, 0, 1)};
    vecs[11] = '{1'b1, 99,  mk(24, 12, 0, 0, 0, 0, 1)};
    vecs[12] = '{1'b1, 1,   mk(0,  0,  1, 0, 0, 0, 1)};

    mh = TH - 1;
    mv = TV - 1;
    mfc = 0;

    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < vecs[i].cycles; k++) step(vecs[i].rst_n);
      a = {hc, vc, hs, vs, ad, nf, fc};
      checks++;
      if (a !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d: got %h want %h", i, a, vecs[i].exp);
      end
    end

    // 61 frames: frame counter must reach 59 and wrap to 0
    for (int k = 0; k < 61 * TH * TV; k++) step(1'b1);
    check("fc_after_62_frames", int'(fc), 62 % FPS);

    // mid-frame reset inside the visible region
    for (int k = 0; k < TH * TV && !(mh == 10 && mv == 5); k++)
      step(1'b1);
    check("mid_h", int'(hc), 10);
    check("mid_v", int'(vc), 5);
    step(1'b0);
    check("rst_h", int'(hc), TH - 1);
    check("rst_v", int'(vc), TV - 1);
    check("rst_nf", int'(nf), 0);
    check("rst_fc", int'(fc), 0);
    step(1'b1);
    check("rel_h", int'(hc), 0);
    check("rel_v", int'(vc), 0);
    check("rel_ad", int'(ad), 1);
    check("rel_nf", int'(nf), 0);
    check("rel_fc", int'(fc), 0);

    // multi-cycle reset hold
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      check("hold_h", int'(hc), TH - 1);
    end
    step(1'b1);
    check("hold_rel_h", int'(hc), 0);

    // three frames under the protocol and run-length checks
    for (int k = 0; k < 3 * TH * TV; k++) step(1'b1);
    check("fc_after_3", int'(fc), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_sig_gen.md
# video_sig_gen

Generates 1280x720 (720p60) raster timing from the pixel clock: horizontal/vertical pixel counters, sync pulses, active-draw flag, a one-cycle new-frame strobe and a frame counter. Sits directly upstream of the pong game logic, which consumes `hcount`, `vcount` and the new-frame strobe to draw sprites and advance game state. The sync, active-draw and pixel-colour outputs together feed the TMDS/HDMI output path.

## Interface

Parameters:
- ACTIVE_H, 1280, visible pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, horizontal sync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- ACTIVE_V, 720, visible lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 20, vertical back porch (lines)
- FPS, 60, frame-counter modulus

Derived values:
- TOTAL_H = ACTIVE_H+H_FP+H_SYNC+H_BP = 1650
- TOTAL_V = ACTIVE_V+V_FP+V_SYNC+V_BP = 750

Ports:
- pixel_clk_in  input  1  pixel clock (74.25 MHz); the only clock
- rst_n_in  input  1  reset; synchronous, active-low
- hcount_out  output  11  current pixel column, 0..TOTAL_H-1
- vcount_out  output  10  current line, 0..TOTAL_V-1
- hs_out  output  1  horizontal sync, active-high
- vs_out  output  1  vertical sync, active-high
- ad_out  output  1  active draw; high only in the visible region
- nf_out  output  1  new-frame strobe, one cycle per frame
- fc_out  output  6  frame count, 0..FPS-1

## Operation

- Single clock, single reset. All outputs are registers updated on the same pixel_clk_in edge; no combinational path from input to output.

Reset (rst_n_in low at an edge):
- hcount_out = TOTAL_H-1 (1649), vcount_out = TOTAL_V-1 (749).
- hs_out, vs_out, ad_out and nf_out = 0; fc_out = 0.

Counting (rst_n_in high):
- hcount wraps from TOTAL_H-1 to 0; otherwise it increments by 1.
- vcount increments only on the hcount wrap edge, and wraps from TOTAL_V-1 to 0 on that edge.
- Consequence: the first edge after reset release presents (0,0).

Output decode, computed from the next counter values so that every output is aligned with the hcount_out/vcount_out it accompanies:
- ad_out = (h < ACTIVE_H) && (v < ACTIVE_V).
- hs_out = 1 for h in [ACTIVE_H+H_FP, ACTIVE_H+H_FP+H_SYNC-1], i.e. 1390..1429.
- vs_out = 1 for v in [ACTIVE_V+V_FP, ACTIVE_V+V_FP+V_SYNC-1], i.e. lines 725..729, for all h.
- nf_out = 1 only when (h,v) = (ACTIVE_H, ACTIVE_V) = (1280,720). This is the first blanking pixel after the last visible line.

Frame counter:
- fc_out increments on the same edge on which nf_out rises.
- It wraps from FPS-1 to 0.

Width rules: comparisons are unsigned; counter widths are sufficient for the defaults, so no overflow is possible.

## Timing

- Latency: output changes on the edge after the counter decision; zero skew between any two outputs.
- Line = 1650 cycles; frame = 1650*750 = 1,237,500 cycles. nf_out pulses are exactly 1,237,500 cycles apart.
- hs_out high for 40 consecutive cycles per line. vs_out high for 5*1650 = 8250 consecutive cycles per frame.
- ad_out high for 1280 consecutive cycles on each of lines 0..719 and low on all other lines.
- Reset mid-frame: the next edge takes the reset values regardless of position. The strobe and counter are cleared, and no nf_out pulse occurs on reset entry or exit.
- Reset held for multiple cycles: outputs stay at reset values.
- Simultaneous end-of-line and end-of-frame at (1649,749): the next edge gives (0,0) with ad_out=1.

## Test plan

- Reset, then release: hold rst_n_in=0 for 5 cycles, release -> during reset (1649,749), ad=0, fc=0; first edge after release gives (0,0), ad=1, hs=vs=nf=0.
- Line timing: run one line -> ad high for cycles with h 0..1279, hs high exactly for h 1390..1429, hcount wraps 1649->0 with vcount 0->1.
- Frame timing: run two frames -> nf_out is a single-cycle pulse at (1280,720), 1,237,500 cycles apart; vs high exactly on lines 725..729; ad never high for v>=720.
- Frame counter wrap: run 61 frames -> fc_out steps 0..59 on each nf edge, then wraps 59->0, with fc changing on the same edge as the nf rise.
- Mid-frame reset: assert rst_n_in=0 at (700,400) for 1 cycle -> reset values next edge, (0,0) on the following edge, fc_out=0, no nf pulse.
- Protocol checker: over 3 frames, assert that hs/vs/ad/nf are always consistent with the hcount_out/vcount_out presented on the same cycle.
